// File: rtl/cpack_line_unpacker_pkg.sv
// rtl/cpack_line_unpacker_pkg.sv - shared codes, prefixes and lengths for the packed-line unpacker
package cpack_pkg;

    localparam int IDX_WIDTH = 4;
    localparam int LEN_WIDTH = 6;

    typedef enum logic [2:0] {
        ZZZZ = 3'd0,
        XXXX = 3'd1,
        MMMM = 3'd2,
        MMXX = 3'd3,
        ZZZX = 3'd4,
        MMMX = 3'd5
    } code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAIR0 = 2'd1,
        ST_PAIR1 = 2'd2
    } state_t;

    // Two-bit prefixes; PFX_EXT selects the four-bit prefix space below
    localparam logic [1:0] PFX_ZZZZ = 2'b00;
    localparam logic [1:0] PFX_XXXX = 2'b01;
    localparam logic [1:0] PFX_MMMM = 2'b10;
    localparam logic [1:0] PFX_EXT  = 2'b11;

    localparam logic [3:0] PFX_MMXX = 4'b0011;
    localparam logic [3:0] PFX_ZZZX = 4'b0111;
    localparam logic [3:0] PFX_MMMX = 4'b1011;
    localparam logic [3:0] PFX_RSVD = 4'b1111;

    localparam logic [LEN_WIDTH-1:0] LEN_ZZZZ = 6'd2;
    localparam logic [LEN_WIDTH-1:0] LEN_XXXX = 6'd34;
    localparam logic [LEN_WIDTH-1:0] LEN_MMMM = 6'd6;
    localparam logic [LEN_WIDTH-1:0] LEN_MMXX = 6'd24;
    localparam logic [LEN_WIDTH-1:0] LEN_ZZZX = 6'd12;
    localparam logic [LEN_WIDTH-1:0] LEN_MMMX = 6'd16;
    localparam logic [LEN_WIDTH-1:0] LEN_RSVD = 6'd4;
    localparam logic [LEN_WIDTH-1:0] LEN_RAW  = 6'd32;

endpackage

// File: rtl/cpack_line_unpacker_if.sv
// rtl/cpack_line_unpacker_if.sv - line-in / decoded-pair-out bundle for the unpacker
interface cpack_line_unpacker_if
    import cpack_pkg::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 32,
    parameter int IDX_W      = 4,
    parameter int PTR_WIDTH  = 8
);
    logic [LINE_WIDTH-1:0] line;
    logic                  line_raw;
    logic                  line_valid;
    logic                  line_ready;
    logic                  pair_valid;
    logic                  pair_ready;
    code_t                 code1;
    code_t                 code2;
    logic [IDX_W-1:0]      idx1;
    logic [IDX_W-1:0]      idx2;
    logic [WORD_WIDTH-1:0] word1;
    logic [WORD_WIDTH-1:0] word2;
    logic                  line_done;
    logic [PTR_WIDTH-1:0]  total_bits;
    logic                  err;

    modport master (
        output line, line_raw, line_valid, pair_ready,
        input  line_ready, pair_valid, code1, code2, idx1, idx2,
               word1, word2, line_done, total_bits, err
    );

    modport slave (
        input  line, line_raw, line_valid, pair_ready,
        output line_ready, pair_valid, code1, code2, idx1, idx2,
               word1, word2, line_done, total_bits, err
    );
endinterface

// File: rtl/cpack_line_unpacker_word_decoder.sv
// rtl/cpack_line_unpacker_word_decoder.sv - decodes one compressed word from an LSB-aligned bit slice
module cpack_word_decoder
    import cpack_pkg::*;
#(
    parameter int WORD_WIDTH    = 32,
    parameter int MAX_CODE_BITS = 34,
    parameter int IDX_W         = 4
) (
    input  logic [MAX_CODE_BITS-1:0] bits_i,
    output code_t                    code_o,
    output logic [IDX_W-1:0]         idx_o,
    output logic [WORD_WIDTH-1:0]    word_o,
    output logic [LEN_WIDTH-1:0]     len_o,
    output logic                     rsvd_o
);

    always_comb begin
        code_o = ZZZZ;
        idx_o  = '0;
        word_o = '0;
        len_o  = LEN_ZZZZ;
        rsvd_o = 1'b0;
        case (bits_i[1:0])
            PFX_XXXX: begin
                code_o = XXXX;
                word_o = WORD_WIDTH'(bits_i[33:2]);
                len_o  = LEN_XXXX;
            end
            PFX_MMMM: begin
                code_o = MMMM;
                idx_o  = IDX_W'(bits_i[5:2]);
                len_o  = LEN_MMMM;
            end
            PFX_EXT: begin
                case (bits_i[3:0])
                    PFX_MMXX: begin
                        code_o = MMXX;
                        idx_o  = IDX_W'(bits_i[7:4]);
                        word_o = WORD_WIDTH'(bits_i[23:8]);
                        len_o  = LEN_MMXX;
                    end
                    PFX_ZZZX: begin
                        code_o = ZZZX;
                        word_o = WORD_WIDTH'(bits_i[11:4]);
                        len_o  = LEN_ZZZX;
                    end
                    PFX_MMMX: begin
                        code_o = MMMX;
                        idx_o  = IDX_W'(bits_i[7:4]);
                        word_o = WORD_WIDTH'(bits_i[15:8]);
                        len_o  = LEN_MMMX;
                    end
                    default: begin
                        // Reserved prefix: skip its four bits so the next slot stays aligned
                        len_o  = LEN_RSVD;
                        rsvd_o = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpack_line_unpacker.sv
// rtl/cpack_line_unpacker.sv - splits a packed 128-bit line into two decoded word pairs
module cpack_line_unpacker
    import cpack_pkg::*;
#(
    parameter int LINE_WIDTH    = 128,
    parameter int WORD_WIDTH    = 32,
    parameter int DICT_WORD     = 16,
    parameter int MAX_CODE_BITS = 34,
    parameter int PTR_WIDTH     = 8
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [LINE_WIDTH-1:0]        i_line,
    input  logic                         i_line_raw,
    input  logic                         i_line_valid,
    output logic                         o_line_ready,
    output logic                         o_pair_valid,
    input  logic                         i_pair_ready,
    output code_t                        o_code1,
    output code_t                        o_code2,
    output logic [$clog2(DICT_WORD)-1:0] o_idx1,
    output logic [$clog2(DICT_WORD)-1:0] o_idx2,
    output logic [WORD_WIDTH-1:0]        o_word1,
    output logic [WORD_WIDTH-1:0]        o_word2,
    output logic                         o_line_done,
    output logic [PTR_WIDTH-1:0]         o_total_bits,
    output logic                         o_err
);

    localparam int IW = $clog2(DICT_WORD);
    localparam logic [PTR_WIDTH:0] LINE_BITS = (PTR_WIDTH+1)'(LINE_WIDTH);

    state_t                  state_q;
    logic [LINE_WIDTH-1:0]   line_q;
    logic                    raw_q;
    logic [PTR_WIDTH-1:0]    ptr_q;
    logic                    line_ready_q;
    logic                    pair_valid_q;
    logic                    line_done_q;
    logic [PTR_WIDTH-1:0]    total_q;
    logic                    err_q;

    logic [MAX_CODE_BITS-1:0] slice1, slice2;
    code_t                    dec_code1, dec_code2;
    logic [IW-1:0]            dec_idx1, dec_idx2;
    logic [WORD_WIDTH-1:0]    dec_word1, dec_word2;
    logic [LEN_WIDTH-1:0]     dec_len1, dec_len2, len1, len2;
    logic                     rsvd1, rsvd2;
    logic [PTR_WIDTH:0]       ptr2, ptr_d;
    logic [2*WORD_WIDTH-1:0]  raw_pair;
    logic                     pair_err;

    // Shifting past the end of the line naturally feeds zeros into the decoders
    assign slice1   = MAX_CODE_BITS'(line_q >> ptr_q);
    assign raw_pair = (2*WORD_WIDTH)'(line_q >> ptr_q);
    assign len1     = raw_q ? LEN_RAW : dec_len1;
    assign len2     = raw_q ? LEN_RAW : dec_len2;
    assign ptr2     = {1'b0, ptr_q} + (PTR_WIDTH+1)'(len1);
    assign slice2   = MAX_CODE_BITS'(line_q >> ptr2);
    assign ptr_d    = ptr2 + (PTR_WIDTH+1)'(len2);
    assign pair_err = !raw_q && ((ptr_d > LINE_BITS) || rsvd1 || rsvd2);

    cpack_word_decoder #(
        .WORD_WIDTH    (WORD_WIDTH),
        .MAX_CODE_BITS (MAX_CODE_BITS),
        .IDX_W         (IW)
    ) u_dec1 (
        .bits_i (slice1),
        .code_o (dec_code1),
        .idx_o  (dec_idx1),
        .word_o (dec_word1),
        .len_o  (dec_len1),
        .rsvd_o (rsvd1)
    );

    cpack_word_decoder #(
        .WORD_WIDTH    (WORD_WIDTH),
        .MAX_CODE_BITS (MAX_CODE_BITS),
        .IDX_W         (IW)
    ) u_dec2 (
        .bits_i (slice2),
        .code_o (dec_code2),
        .idx_o  (dec_idx2),
        .word_o (dec_word2),
        .len_o  (dec_len2),
        .rsvd_o (rsvd2)
    );

    // Fields read as idle values whenever no pair is presented
    always_comb begin
        o_code1 = ZZZZ;
        o_code2 = ZZZZ;
        o_idx1  = '0;
        o_idx2  = '0;
        o_word1 = '0;
        o_word2 = '0;
        if (pair_valid_q) begin
            if (raw_q) begin
                o_code1 = XXXX;
                o_code2 = XXXX;
                o_word1 = raw_pair[WORD_WIDTH-1:0];
                o_word2 = raw_pair[2*WORD_WIDTH-1:WORD_WIDTH];
            end else begin
                o_code1 = dec_code1;
                o_code2 = dec_code2;
                o_idx1  = dec_idx1;
                o_idx2  = dec_idx2;
                o_word1 = dec_word1;
                o_word2 = dec_word2;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            line_q       <= '0;
            raw_q        <= 1'b0;
            ptr_q        <= '0;
            line_ready_q <= 1'b1;
            pair_valid_q <= 1'b0;
            line_done_q  <= 1'b0;
            total_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_line_valid) begin
                        line_q       <= i_line;
                        raw_q        <= i_line_raw;
                        ptr_q        <= '0;
                        line_ready_q <= 1'b0;
                        pair_valid_q <= 1'b1;
                        state_q      <= ST_PAIR0;
                    end
                end
                ST_PAIR0: begin
                    if (i_pair_ready) begin
                        ptr_q   <= ptr_d[PTR_WIDTH-1:0];
                        err_q   <= pair_err;
                        state_q <= ST_PAIR1;
                    end
                end
                ST_PAIR1: begin
                    if (i_pair_ready) begin
                        ptr_q        <= ptr_d[PTR_WIDTH-1:0];
                        err_q        <= pair_err;
                        line_done_q  <= 1'b1;
                        total_q      <= ptr_d[PTR_WIDTH-1:0];
                        line_ready_q <= 1'b1;
                        pair_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    line_ready_q <= 1'b1;
                    pair_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_line_ready = line_ready_q;
    assign o_pair_valid = pair_valid_q;
    assign o_line_done  = line_done_q;
    assign o_total_bits = total_q;
    assign o_err        = err_q;

endmodule

// File: doc/cpack_line_unpacker.md
Name: cpack_line_unpacker

Overview:
- Receive side of the compressed-line packer: accepts one 128-bit packed line, either compressed or raw (the backup-buffer path), and emits its four 32-bit word slots as two pairs of decoded (code, dictionary index, payload) fields, one pair per handshake.
- Sits in front of the dictionary-lookup/reconstruction stage of the decompressor.
- Walks the LSB-first bit stream with a bit pointer, mirroring the packer's word1-low / word2-shifted-left ordering.

Parameters:
- LINE_WIDTH, 128, packed line width (CACHE_LINE*2).
- WORD_WIDTH, 32, uncompressed word width.
- DICT_WORD, 16, dictionary entries; index width is $clog2(DICT_WORD)=4.
- MAX_CODE_BITS, 34, longest compressed word.
- PTR_WIDTH, 8, bit-pointer width (0..255).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_line  in  LINE_WIDTH  packed line
- i_line_raw  in  1  line holds 4 uncompressed words (stop-flag case)
- i_line_valid  in  1  line offered
- o_line_ready  out  1  block idle, line accepted on valid&ready
- o_pair_valid  out  1  decoded pair presented
- i_pair_ready  in  1  consumer takes pair
- o_code1, o_code2  out  3  internal code enum of word slot 2k / 2k+1
- o_idx1, o_idx2  out  4  dictionary index (0 when unused)
- o_word1, o_word2  out  WORD_WIDTH  payload, zero-extended
- o_line_done  out  1  one-cycle pulse after last pair accepted
- o_total_bits  out  PTR_WIDTH  bits consumed by the line, valid with o_line_done
- o_err  out  1  one-cycle pulse: reserved prefix or stream overruns LINE_WIDTH

Behaviour:
- Clocking: one clock, i_clk; reset synchronous active-high on i_reset. The ports above fix this.
- Reset values: state IDLE, line register 0, pointer 0.
  - Outputs: o_line_ready=1 (the cycle after reset deasserts), o_pair_valid=0, o_line_done=0, o_err=0, o_total_bits=0.
  - Decode fields: code=ZZZZ, idx=0, word=0.
- FSM IDLE -> PAIR0 -> PAIR1 -> IDLE.
  - IDLE: o_line_ready=1. On i_line_valid, register the line and raw flag, clear the pointer, go to PAIR0.
  - First pair is valid the next cycle (latency 1).
- PAIR0/PAIR1: o_pair_valid=1.
  - Fields are decoded combinationally from (line >> ptr) and held stable while i_pair_ready=0.
  - On acceptance, ptr += len1+len2, then advance state.
  - Leaving PAIR1 pulses o_line_done and loads o_total_bits with the final pointer.
  - i_line_valid is ignored outside IDLE.
- Wire format (LSB first, prefix in low bits of each compressed word):
  - 2'b00 ZZZZ: len 2.
  - 2'b01 XXXX: payload [33:2], len 34.
  - 2'b10 MMMM: idx [5:2], len 6.
  - 4'b0011 MMXX: idx [7:4], low halfword [23:8], len 24.
  - 4'b0111 ZZZX: low byte [11:4], len 12.
  - 4'b1011 MMMX: idx [7:4], low byte [15:8], len 16.
  - 4'b1111 is reserved.
- Word 2 of a pair starts at ptr+len1.
- Raw line: no prefix parsing. Slot k = i_line[32k+31:32k], code=XXXX, idx=0, len 32 each; o_total_bits=128.
- Overrun: bits at or above LINE_WIDTH read as 0. If ptr+len1+len2 > LINE_WIDTH on a compressed line, o_err pulses on that pair's acceptance; the pair is still delivered.
- Reserved prefix: decode as ZZZZ with len 4, and o_err pulses on acceptance.
- Reset mid-line: the line is abandoned and no o_line_done is produced.

Decomposition:
- Package cpack_pkg:
  - code_t enum (ZZZZ=0, XXXX=1, MMMM=2, MMXX=3, ZZZX=4, MMMX=5), shared with the packer's code_concatenator.
  - Prefix localparams and per-code length constants.
- Sub-module cpack_word_decoder: combinational, MAX_CODE_BITS slice in, code/idx/payload/len out. Instantiated twice.

Test Plan:
- All-zero compressed line, pair_ready=1 -> 4×ZZZZ over 2 pairs, o_total_bits=8, o_err=0, done pulse 2 cycles after acceptance.
- line[33:0]={32'hDEADBEEF,2'b01}, line[39:34]={4'd5,2'b10}, rest 0 -> pair0 = XXXX/DEADBEEF, MMMM idx 5; pair1 = ZZZZ, ZZZZ; total 44.
- 4×XXXX starting at bit 0 -> pair1 overruns (136>128) -> o_err pulse on pair1; word3 upper 8 bits = 0.
- i_line_raw=1, line=128'h44444444_33333333_22222222_11111111 -> words 11111111/22222222 then 33333333/44444444, all XXXX, total 128.
- i_pair_ready held low 5 cycles in PAIR0 -> outputs stable and o_line_ready=0; a new i_line_valid pulse is ignored.
- Prefix 4'b1111 at bit 0 -> o_err pulse, slot0 code ZZZZ, slot1 decoded from bit 4; i_reset in PAIR1 -> next cycle IDLE with all outputs at reset values.
